// File: rtl/arrow_key_encoder_pkg.sv
// Direction codes shared by the key encoder, sequence checker and display.
// Code of key i is (i+1) mod N_KEYS; all-ones means no direction.
package arrow_pkg;

  localparam int DIR_W_DEF = 3;

  localparam logic [DIR_W_DEF-1:0] DIR_DOWN  = 3'b001;
  localparam logic [DIR_W_DEF-1:0] DIR_UP    = 3'b010;
  localparam logic [DIR_W_DEF-1:0] DIR_RIGHT = 3'b011;
  localparam logic [DIR_W_DEF-1:0] DIR_LEFT  = 3'b000;
  localparam logic [DIR_W_DEF-1:0] DIR_NONE  = 3'b111;

  function automatic int key_to_dir(
    input int idx,
    input int n_keys
  );
    return (idx + 1) % n_keys;
  endfunction

endpackage

// File: rtl/arrow_key_encoder_if.sv
// Valid/ready direction-event channel from the encoder to the checker.
// master drives the event, slave returns ready.
interface arrow_key_encoder_if
  import arrow_pkg::*;
#(
  parameter int DIR_W = DIR_W_DEF
);

  logic             dir_valid;
  logic [DIR_W-1:0] dir_code;
  logic             dir_ready;

  modport master (
    output dir_valid,
    output dir_code,
    input  dir_ready
  );

  modport slave (
    input  dir_valid,
    input  dir_code,
    output dir_ready
  );

endinterface

// File: rtl/arrow_key_encoder_debounce.sv
// One key: 2-FF synchroniser, stability counter, debounced level
// and a registered one-cycle pulse when the level rises.
module key_debounce
  import arrow_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned KEY_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          pin;
  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  // Normalise polarity so that 1 always means pressed downstream.
  assign pin = (KEY_ACTIVE_LOW != 0) ? ~key_i : key_i;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/arrow_key_encoder.sv
// Debounced arrow keys -> single-press direction events on a
// one-entry valid/ready slot, plus the held-direction level.
module arrow_key_encoder
  import arrow_pkg::*;
#(
  parameter int          N_KEYS          = 4,
  parameter int          DIR_W           = DIR_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned KEY_ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_KEYS-1:0] key_in,
  input  logic              en,
  arrow_key_encoder_if.master dir_bus,
  output logic [DIR_W-1:0]  dir_level,
  output logic              chord_err,
  output logic              overrun
);

  localparam logic [DIR_W-1:0] NONE = '1;

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] rise;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_deb (
      .clk     (clk),
      .resetn  (resetn),
      .key_i   (key_in[i]),
      .level_o (level[i]),
      .rise_o  (rise[i])
    );
  end

  logic             single;
  logic             ev;
  logic [DIR_W-1:0] ev_code;
  logic [DIR_W-1:0] lvl_code;
  logic             accept;

  logic             valid_q, valid_d;
  logic [DIR_W-1:0] code_q, code_d;
  logic [DIR_W-1:0] lvl_q;
  logic             chord_q, chord_d;
  logic             ovr_q, ovr_d;

  // A press is clean only if it is the sole rise and nothing else is held.
  assign single = $onehot(rise) && ((level & ~rise) == '0);
  assign ev     = en && single;
  assign accept = valid_q && dir_bus.dir_ready;

  always_comb begin
    ev_code  = NONE;
    lvl_code = NONE;
    for (int i = 0; i < N_KEYS; i++) begin
      if (rise[i]) ev_code = DIR_W'(key_to_dir(i, N_KEYS));
      if (level[i] && $onehot(level))
        lvl_code = DIR_W'(key_to_dir(i, N_KEYS));
    end
  end

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovr_d   = 1'b0;
    chord_d = (|rise) && !single;
    if (ev) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        code_d  = ev_code;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
      code_d  = NONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      code_q  <= NONE;
      lvl_q   <= NONE;
      chord_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      lvl_q   <= lvl_code;
      chord_q <= chord_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dir_bus.dir_valid = valid_q;
  assign dir_bus.dir_code  = code_q;
  assign dir_level         = lvl_q;
  assign chord_err         = chord_q;
  assign overrun           = ovr_q;

endmodule

// File: tb/tb_arrow_key_encoder.sv
// Bench for arrow_key_encoder with a short debounce window;
// accepted events are matched against a queue of expected codes.
module tb_arrow_key_encoder;
  import arrow_pkg::*;

  logic       clk;
  logic       resetn;
  logic [3:0] key_in;
  logic       en;
  logic [2:0] dir_level;
  logic       chord_err;
  logic       overrun;

  int vec;
  int miss;
  int evt_cnt;
  int chord_cnt;
  int ovr_cnt;
  logic [2:0] exp_q[$];

  arrow_key_encoder_if #(.DIR_W(3)) bus ();

  arrow_key_encoder #(
    .N_KEYS          (4),
    .DIR_W           (3),
    .DEBOUNCE_CYCLES (4),
    .KEY_ACTIVE_LOW  (1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_in    (key_in),
    .en        (en),
    .dir_bus   (bus.master),
    .dir_level (dir_level),
    .chord_err (chord_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: observes the slot just before each accepting edge.
  always begin
    logic [2:0] e;
    @(negedge clk);
    #1;
    if (resetn) begin
      if (chord_err) chord_cnt++;
      if (overrun) ovr_cnt++;
      if (bus.dir_valid && bus.dir_ready) begin
        evt_cnt++;
        vec++;
        if (exp_q.size() == 0) begin
          miss++;
          $display("FAIL sb_unexpected got=%b required=none",
                   bus.dir_code);
        end else begin
          e = exp_q.pop_front();
          if (bus.dir_code !== e) begin
            miss++;
            $display("FAIL sb_code got=%b required=%b",
                     bus.dir_code, e);
          end
        end
      end
    end
  end

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    key_in = 4'b0000;
    en = 1'b1;
    bus.dir_ready = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (bus.dir_valid !== 1'b0) begin
      miss++;
      $display("FAIL rst_valid got=%b required=0", bus.dir_valid);
    end
    vec++;
    if (bus.dir_code !== 3'b111) begin
      miss++;
      $display("FAIL rst_code got=%b required=111", bus.dir_code);
    end
    vec++;
    if (dir_level !== 3'b111) begin
      miss++;
      $display("FAIL rst_level got=%b required=111", dir_level);
    end
    vec++;
    if (chord_err !== 1'b0 || overrun !== 1'b0) begin
      miss++;
      $display("FAIL rst_pulses got=%b%b required=00",
               chord_err, overrun);
    end
    key_in = 4'b1011;
    resetn = 1'b1;
    exp_q.push_back(DIR_RIGHT);
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      vec++;
      if (bus.dir_valid !== 1'b0) begin
        miss++;
        $display("FAIL rst_early k=%0d got=%b required=0",
                 k, bus.dir_valid);
      end
    end
    @(negedge clk);
    vec++;
    if (bus.dir_valid !== 1'b1 || bus.dir_code !== 3'b011) begin
      miss++;
      $display("FAIL rst_event got=%b/%b required=1/011",
               bus.dir_valid, bus.dir_code);
    end
    vec++;
    if (dir_level !== 3'b011) begin
      miss++;
      $display("FAIL rst_lvl got=%b required=011", dir_level);
    end
    @(negedge clk);
    vec++;
    if (bus.dir_valid !== 1'b0) begin
      miss++;
      $display("FAIL rst_pulse_len got=%b required=0",
               bus.dir_valid);
    end
    key_in = 4'b1111;
    settle();
  endtask

  task automatic test_bounce();
    int e0;
    int c0;
    e0 = evt_cnt;
    c0 = chord_cnt;
    for (int t = 0; t < 10; t++) begin
      key_in[0] = t[0];
      repeat (2) @(negedge clk);
    end
    key_in[0] = 1'b0;
    exp_q.push_back(DIR_DOWN);
    repeat (12) @(negedge clk);
    vec++;
    if (evt_cnt - e0 !== 1) begin
      miss++;
      $display("FAIL bounce_events got=%0d required=1", evt_cnt - e0);
    end
    vec++;
    if (chord_cnt !== c0) begin
      miss++;
      $display("FAIL bounce_chord got=%0d required=0", chord_cnt - c0);
    end
    key_in = 4'b1111;
    settle();
  endtask

  task automatic test_chord();
    int e0;
    int c0;
    key_in[1] = 1'b0;
    exp_q.push_back(DIR_UP);
    settle();
    e0 = evt_cnt;
    c0 = chord_cnt;
    key_in[3] = 1'b0;
    settle();
    vec++;
    if (evt_cnt !== e0) begin
      miss++;
      $display("FAIL chord_events got=%0d required=0", evt_cnt - e0);
    end
    vec++;
    if (chord_cnt - c0 !== 1) begin
      miss++;
      $display("FAIL chord_pulses got=%0d required=1", chord_cnt - c0);
    end
    vec++;
    if (dir_level !== 3'b111) begin
      miss++;
      $display("FAIL chord_level got=%b required=111", dir_level);
    end
    key_in = 4'b1111;
    settle();
  endtask

  task automatic test_backpressure();
    int o0;
    bus.dir_ready = 1'b0;
    o0 = ovr_cnt;
    key_in[1] = 1'b0;
    settle();
    key_in[1] = 1'b1;
    settle();
    key_in[3] = 1'b0;
    settle();
    vec++;
    if (bus.dir_valid !== 1'b1 || bus.dir_code !== 3'b010) begin
      miss++;
      $display("FAIL bp_held got=%b/%b required=1/010",
               bus.dir_valid, bus.dir_code);
    end
    vec++;
    if (ovr_cnt - o0 !== 1) begin
      miss++;
      $display("FAIL bp_overrun got=%0d required=1", ovr_cnt - o0);
    end
    exp_q.push_back(DIR_UP);
    bus.dir_ready = 1'b1;
    repeat (2) @(negedge clk);
    vec++;
    if (bus.dir_valid !== 1'b0 || bus.dir_code !== 3'b111) begin
      miss++;
      $display("FAIL bp_drain got=%b/%b required=0/111",
               bus.dir_valid, bus.dir_code);
    end
    key_in = 4'b1111;
    settle();
    bus.dir_ready = 1'b0;
    o0 = ovr_cnt;
    key_in[1] = 1'b0;
    settle();
    key_in[1] = 1'b1;
    settle();
    key_in[3] = 1'b0;
    repeat (6) @(negedge clk);
    exp_q.push_back(DIR_UP);
    exp_q.push_back(DIR_LEFT);
    bus.dir_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (bus.dir_valid !== 1'b1 || bus.dir_code !== 3'b000) begin
      miss++;
      $display("FAIL bp_swap got=%b/%b required=1/000",
               bus.dir_valid, bus.dir_code);
    end
    @(negedge clk);
    vec++;
    if (ovr_cnt !== o0) begin
      miss++;
      $display("FAIL bp_swap_ovr got=%0d required=0", ovr_cnt - o0);
    end
    key_in = 4'b1111;
    settle();
  endtask

  task automatic test_enable();
    int e0;
    e0 = evt_cnt;
    en = 1'b0;
    key_in[2] = 1'b0;
    settle();
    vec++;
    if (bus.dir_valid !== 1'b0 || evt_cnt !== e0) begin
      miss++;
      $display("FAIL en_off got=%b/%0d required=0/0",
               bus.dir_valid, evt_cnt - e0);
    end
    vec++;
    if (dir_level !== 3'b011) begin
      miss++;
      $display("FAIL en_level got=%b required=011", dir_level);
    end
    en = 1'b1;
    settle();
    vec++;
    if (bus.dir_valid !== 1'b0 || evt_cnt !== e0) begin
      miss++;
      $display("FAIL en_late got=%b/%0d required=0/0",
               bus.dir_valid, evt_cnt - e0);
    end
    key_in = 4'b1111;
    settle();
  endtask

  task automatic test_mid_reset();
    bus.dir_ready = 1'b0;
    key_in[0] = 1'b0;
    settle();
    vec++;
    if (bus.dir_valid !== 1'b1 || bus.dir_code !== 3'b001) begin
      miss++;
      $display("FAIL mr_pending got=%b/%b required=1/001",
               bus.dir_valid, bus.dir_code);
    end
    resetn = 1'b0;
    #1;
    vec++;
    if (bus.dir_valid !== 1'b0 || bus.dir_code !== 3'b111) begin
      miss++;
      $display("FAIL mr_async got=%b/%b required=0/111",
               bus.dir_valid, bus.dir_code);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      vec++;
      if (bus.dir_valid !== 1'b0) begin
        miss++;
        $display("FAIL mr_early k=%0d got=%b required=0",
                 k, bus.dir_valid);
      end
    end
    @(negedge clk);
    vec++;
    if (bus.dir_valid !== 1'b1 || bus.dir_code !== 3'b001) begin
      miss++;
      $display("FAIL mr_event got=%b/%b required=1/001",
               bus.dir_valid, bus.dir_code);
    end
    exp_q.push_back(DIR_DOWN);
    bus.dir_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (bus.dir_valid !== 1'b0) begin
      miss++;
      $display("FAIL mr_drain got=%b required=0", bus.dir_valid);
    end
    key_in = 4'b1111;
    settle();
  endtask

  initial begin
    vec = 0;
    miss = 0;
    evt_cnt = 0;
    chord_cnt = 0;
    ovr_cnt = 0;
    test_reset();
    test_bounce();
    test_chord();
    test_backpressure();
    test_enable();
    test_mid_reset();
    vec++;
    if (exp_q.size() != 0) begin
      miss++;
      $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
